dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares one single-port, byte-enabled data memory between the core load/store unit (C port) and
//  the program/data loader (L port). Arbitrates per cycle and issues one memory command per cycle.
//  Converts RV32 funct3 accesses into word address, byte enables and lane-replicated store data.
//  Returns aligned, sign/zero-extended load data to the requester that issued the read.
// PARAMETERS
//  STARVE_LIMIT  4   max consecutive C grants while L is requesting; L then wins the next grant (>=1)
// PORTS
//  i_clk         in   1   clock, all logic on rising edge
//  i_rst         in   1   reset, synchronous, active-high
//  i_c_req       in   1   core request; held with fields stable until o_c_gnt
//  i_c_we        in   1   core: 1=store, 0=load
//  i_c_addr      in   32  core byte address
//  i_c_wdata     in   32  core store data (low bits valid for SB/SH)
//  i_c_funct3    in   3   core access type: LB/LH/LW/LBU/LHU, SB/SH/SW
//  o_c_gnt       out  1   core request accepted this cycle (combinational)
//  o_c_rvalid    out  1   core load data valid, exactly one cycle after the read grant
//  o_c_rdata     out  32  core load data, aligned and extended
//  o_c_err       out  1   misaligned or illegal-funct3 access, one cycle after grant
//  i_l_req       in   1   loader request (word accesses only); held until o_l_gnt
//  i_l_we        in   1   loader: 1=store, 0=load
//  i_l_addr      in   32  loader byte address, bits [1:0] ignored
//  i_l_wdata     in   32  loader store word
//  o_l_gnt       out  1   loader request accepted this cycle (combinational)
//  o_l_rvalid    out  1   loader read data valid, one cycle after the read grant
//  o_l_rdata     out  32  loader read word
//  o_m_en        out  1   memory access strobe
//  o_m_we        out  1   memory write
//  o_m_addr      out  30  memory word address (byte address >> 2)
//  o_m_be        out  4   memory byte enables, bit n = byte lane n
//  o_m_wdata     out  32  memory write data, lane-replicated
//  i_m_rdata     in   32  memory read word, valid one cycle after o_m_en && !o_m_we
// BEHAVIOUR
//  - Reset: all o_*rvalid, o_c_err = 0; starve counter = 0; response-tracking regs cleared; rdata = 0.
//  - Grant: fixed priority to C, except when starve_cnt == STARVE_LIMIT and i_l_req, then L wins.
//    At most one gnt per cycle; gnt never asserted without req; gnt forced 0 while i_rst.
//  - starve_cnt: +1 on each C grant while i_l_req=1, saturating at STARVE_LIMIT; cleared on L grant
//    or whenever i_l_req=0.
//  - Memory command is driven combinationally in the grant cycle; o_m_en = 0 when nothing is granted.
//  - Stores: SB be=0001<<a[1:0], data={4{wdata[7:0]}}; SH be=0011<<{a[1],1'b0}, data={2{wdata[15:0]}};
//    SW/L-store be=1111. Loads drive be=1111.
//  - Misaligned C access (H with a[0]=1, W with a[1:0]!=0) or undefined funct3: granted, o_m_en = 0,
//    o_c_err pulses next cycle, o_c_rvalid stays 0. L accesses never raise an error.
//  - Read response: register {owner, funct3, a[1:0]} at grant; next cycle select lane from i_m_rdata,
//    LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through. Exactly one rvalid pulse per read grant.
//  - Back-to-back: a new grant may issue in the same cycle as the previous read's rvalid (full
//    throughput, 1 access/cycle). Write then read of the same word on consecutive cycles returns the
//    new data (the memory is write-first).
//  - Reset mid-operation: an outstanding read response is dropped (no rvalid after reset).
//  - rdata holds its last value when rvalid = 0.
// STRUCTURE
//  - dmem_pkg: funct3 enum (F3_B/H/W/BU/HU), owner enum (OWN_CORE/OWN_LOADER), be_for() function.
//  - Sub-module dmem_lane_align: combinational store lane-replication + load extract/extend;
//    the arbiter keeps grant logic, starve counter and response pipeline registers.
// TESTING
//  1 C SB a=0x103 wdata=0xAB -> m_addr=0x40, be=1000, m_wdata=0xABABABAB; LB same addr -> 0xFFFFFFAB.
//  2 mem word 0x80F0_7F01 at 0x40; C LH a=0x102 -> 0xFFFF80F0, LHU -> 0x000080F0, LBU a=0x101 -> 0x7F.
//  3 C and L request continuously -> L granted on every 5th cycle (STARVE_LIMIT=4), C otherwise.
//  4 C LW a=0x102 -> c_gnt=1, m_en=0, c_err=1 next cycle, c_rvalid=0; LH a=0x101 -> same.
//  5 C SW 0x1234_5678 @0x200, C LW @0x200 next cycle -> c_rvalid 1 cycle later with 0x12345678.
//  6 L read granted, i_rst asserted next cycle -> no o_l_rvalid; all outputs at reset values.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter: RV32 load/store
// access widths, response owner tags and the per-access legality and
// byte-enable rules.
package dmem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic {
    OWN_CORE   = 1'b0,
    OWN_LOADER = 1'b1
  } owner_e;

  // Byte enables for a core access; loads always fetch the whole word.
  function automatic logic [3:0] be_for(input logic we, input logic [2:0] f3,
                                        input logic [1:0] a);
    logic [3:0] be;
    be = 4'b1111;
    if (we) begin
      case (f3)
        F3_B:    be = 4'b0001 << a;
        F3_H:    be = 4'b0011 << {a[1], 1'b0};
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  // A core access is issued only when funct3 is defined for its direction
  // and the address is naturally aligned for the access width.
  function automatic logic access_ok(input logic we, input logic [2:0] f3,
                                     input logic [1:0] a);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = !a[0];
      F3_W:    ok = (a == 2'b00);
      F3_BU:   ok = !we;
      F3_HU:   ok = !we && !a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core port, loader port and memory command/response port.
// The arbiter takes the slave view; the surrounding system takes the master.
interface dmem_arbiter_if;
  logic        i_c_req;
  logic        i_c_we;
  logic [31:0] i_c_addr;
  logic [31:0] i_c_wdata;
  logic [2:0]  i_c_funct3;
  logic        o_c_gnt;
  logic        o_c_rvalid;
  logic [31:0] o_c_rdata;
  logic        o_c_err;
  logic        i_l_req;
  logic        i_l_we;
  logic [31:0] i_l_addr;
  logic [31:0] i_l_wdata;
  logic        o_l_gnt;
  logic        o_l_rvalid;
  logic [31:0] o_l_rdata;
  logic        o_m_en;
  logic        o_m_we;
  logic [29:0] o_m_addr;
  logic [3:0]  o_m_be;
  logic [31:0] o_m_wdata;
  logic [31:0] i_m_rdata;

  modport slave (
    input  i_c_req, i_c_we, i_c_addr, i_c_wdata, i_c_funct3,
    output o_c_gnt, o_c_rvalid, o_c_rdata, o_c_err,
    input  i_l_req, i_l_we, i_l_addr, i_l_wdata,
    output o_l_gnt, o_l_rvalid, o_l_rdata,
    output o_m_en, o_m_we, o_m_addr, o_m_be, o_m_wdata,
    input  i_m_rdata
  );

  modport master (
    output i_c_req, i_c_we, i_c_addr, i_c_wdata, i_c_funct3,
    input  o_c_gnt, o_c_rvalid, o_c_rdata, o_c_err,
    output i_l_req, i_l_we, i_l_addr, i_l_wdata,
    input  o_l_gnt, o_l_rvalid, o_l_rdata,
    input  o_m_en, o_m_we, o_m_addr, o_m_be, o_m_wdata,
    output i_m_rdata
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane handling: replicates store data across byte lanes and
// extracts/extends a load result from the returned memory word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  st_f3,
  input  logic [31:0] st_wdata,
  output logic [31:0] st_data,
  input  logic [2:0]  ld_f3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Replicate narrow store data so every enabled lane sees the right byte.
  always_comb begin
    case (st_f3)
      F3_B:    st_data = {4{st_wdata[7:0]}};
      F3_H:    st_data = {2{st_wdata[15:0]}};
      default: st_data = st_wdata;
    endcase
  end

  // Select the addressed lane and sign/zero-extend per access type.
  always_comb begin
    ld_byte = ld_word[{ld_off, 3'b000} +: 8];
    ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_f3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the core LSU and the loader.
// Core has priority; a starvation counter hands the loader one grant after
// STARVE_LIMIT consecutive core grants while the loader waits.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic            i_clk,
  input logic            i_rst,
  dmem_arbiter_if.slave  bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic          c_gnt, l_gnt, c_ok;
  logic [31:0]   st_data, ld_data;
  logic          m_en, m_we;
  logic [29:0]   m_addr;
  logic [3:0]    m_be;
  logic [31:0]   m_wdata;
  logic          c_rvalid, l_rvalid;
  logic [CW-1:0] starve_q, starve_d;
  logic          rd_pend_q, rd_pend_d;
  logic          err_q, err_d;
  owner_e        own_q, own_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   c_hold_q, c_hold_d;
  logic [31:0]   l_hold_q, l_hold_d;
  logic          unused_l_addr_bits;

  assign unused_l_addr_bits = ^bus.i_l_addr[1:0];

  dmem_lane_align u_align (
    .st_f3    (bus.i_c_funct3),
    .st_wdata (bus.i_c_wdata),
    .st_data  (st_data),
    .ld_f3    (f3_q),
    .ld_off   (off_q),
    .ld_word  (bus.i_m_rdata),
    .ld_data  (ld_data)
  );

  // Grant selection, memory command and next-state for the response pipeline.
  always_comb begin
    c_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!i_rst) begin
      if (bus.i_l_req && (starve_q == LIM || !bus.i_c_req)) l_gnt = 1'b1;
      else if (bus.i_c_req)                                  c_gnt = 1'b1;
    end
    c_ok = access_ok(bus.i_c_we, bus.i_c_funct3, bus.i_c_addr[1:0]);

    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_be    = '0;
    m_wdata = '0;
    if (c_gnt) begin
      m_en    = c_ok;
      m_we    = bus.i_c_we;
      m_addr  = bus.i_c_addr[31:2];
      m_be    = be_for(bus.i_c_we, bus.i_c_funct3, bus.i_c_addr[1:0]);
      m_wdata = st_data;
    end else if (l_gnt) begin
      m_en    = 1'b1;
      m_we    = bus.i_l_we;
      m_addr  = bus.i_l_addr[31:2];
      m_be    = 4'b1111;
      m_wdata = bus.i_l_wdata;
    end

    if (!bus.i_l_req || l_gnt)         starve_d = '0;
    else if (c_gnt && starve_q != LIM) starve_d = starve_q + 1'b1;
    else                               starve_d = starve_q;

    rd_pend_d = (c_gnt && c_ok && !bus.i_c_we) || (l_gnt && !bus.i_l_we);
    err_d     = c_gnt && !c_ok;
    own_d     = l_gnt ? OWN_LOADER : OWN_CORE;
    f3_d      = bus.i_c_funct3;
    off_d     = bus.i_c_addr[1:0];

    // Responses are suppressed during reset so nothing leaks out of it.
    c_rvalid = rd_pend_q && (own_q == OWN_CORE) && !i_rst;
    l_rvalid = rd_pend_q && (own_q == OWN_LOADER) && !i_rst;
    c_hold_d = c_rvalid ? ld_data : c_hold_q;
    l_hold_d = l_rvalid ? bus.i_m_rdata : l_hold_q;
  end

  // Starve counter, response tags and last-returned data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_q  <= '0;
      rd_pend_q <= 1'b0;
      err_q     <= 1'b0;
      own_q     <= OWN_CORE;
      f3_q      <= '0;
      off_q     <= '0;
      c_hold_q  <= '0;
      l_hold_q  <= '0;
    end else begin
      starve_q  <= starve_d;
      rd_pend_q <= rd_pend_d;
      err_q     <= err_d;
      own_q     <= own_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      c_hold_q  <= c_hold_d;
      l_hold_q  <= l_hold_d;
    end
  end

  assign bus.o_c_gnt    = c_gnt;
  assign bus.o_l_gnt    = l_gnt;
  assign bus.o_m_en     = m_en;
  assign bus.o_m_we     = m_we;
  assign bus.o_m_addr   = m_addr;
  assign bus.o_m_be     = m_be;
  assign bus.o_m_wdata  = m_wdata;
  assign bus.o_c_rvalid = c_rvalid;
  assign bus.o_l_rvalid = l_rvalid;
  assign bus.o_c_err    = err_q && !i_rst;
  assign bus.o_c_rdata  = i_rst ? 32'd0 : (c_rvalid ? ld_data : c_hold_q);
  assign bus.o_l_rdata  = i_rst ? 32'd0 : (l_rvalid ? bus.i_m_rdata : l_hold_q);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory and a response
// scoreboard for both requesters.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Behavioural single-port memory, one-cycle read latency.
  logic [31:0] mem [0:1023];
  logic [31:0] m_rdata_q = 32'd0;
  logic [31:0] mm_w;
  assign bus.i_m_rdata = m_rdata_q;

  always @(posedge clk) begin
    if (bus.o_m_en) begin
      if (bus.o_m_we) begin
        mm_w = mem[bus.o_m_addr[9:0]];
        for (int b = 0; b < 4; b++)
          if (bus.o_m_be[b]) mm_w[8*b +: 8] = bus.o_m_wdata[8*b +: 8];
        mem[bus.o_m_addr[9:0]] <= mm_w;
      end else begin
        m_rdata_q <= mem[bus.o_m_addr[9:0]];
      end
    end
  end

  // Reference memory image, updated in grant order by the stimulus.
  logic [31:0] ref_mem [0:1023];

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t cq[$];
  exp_t lq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit c_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000:  return 1'b1;
      3'b001:  return a[0] == 1'b0;
      3'b010:  return a[1:0] == 2'b00;
      3'b100:  return !we;
      3'b101:  return !we && a[0] == 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = ref_mem[a[11:2]];
    b = w[8*int'(a[1:0]) +: 8];
    h = w[16*int'(a[1]) +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    w = ref_mem[a[11:2]];
    case (f3)
      3'b000:  w[8*int'(a[1:0]) +: 8] = d[7:0];
      3'b001:  w[16*int'(a[1]) +: 16] = d[15:0];
      default: w = d;
    endcase
    ref_mem[a[11:2]] = w;
  endtask

  // Scoreboard: every response must match the oldest expectation, one cycle after grant.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.o_c_rvalid || bus.o_c_err) begin
        total++;
        assert (cq.size() != 0)
        else begin
          bad++;
          $error("FAIL c_unexpected_resp observed=rvalid%0d/err%0d expected=none",
                 bus.o_c_rvalid, bus.o_c_err);
        end
        if (cq.size() != 0) begin
          e = cq.pop_front();
          chk("c_resp_cycle", cyc, e.cyc + 1);
          chk("c_err", {31'd0, bus.o_c_err}, {31'd0, e.is_err});
          chk("c_rvalid", {31'd0, bus.o_c_rvalid}, {31'd0, !e.is_err});
          if (!e.is_err) chk("c_rdata", bus.o_c_rdata, e.data);
        end
      end
      if (bus.o_l_rvalid) begin
        total++;
        assert (lq.size() != 0)
        else begin
          bad++;
          $error("FAIL l_unexpected_resp observed=rvalid expected=none");
        end
        if (lq.size() != 0) begin
          e = lq.pop_front();
          chk("l_resp_cycle", cyc, e.cyc + 1);
          chk("l_rdata", bus.o_l_rdata, e.data);
        end
      end
    end
  end

  task automatic c_op(input bit we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d, input string tag);
    int   n;
    bit   ok;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    bus.i_c_req = 1'b1; bus.i_c_we = we; bus.i_c_funct3 = f3;
    bus.i_c_addr = a; bus.i_c_wdata = d;
    n = 0;
    @(negedge clk);
    while (!bus.o_c_gnt && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_gnt"}, {31'd0, bus.o_c_gnt}, 32'd1);
    ok = c_legal(we, f3, a);
    chk({tag, "_m_en"}, {31'd0, bus.o_m_en}, {31'd0, ok});
    if (ok) begin
      ebe = 4'b1111;
      ewd = d;
      if (we && f3 == 3'b000) begin ebe = 4'b0001 << a[1:0]; ewd = {4{d[7:0]}}; end
      if (we && f3 == 3'b001) begin ebe = a[1] ? 4'b1100 : 4'b0011; ewd = {2{d[15:0]}}; end
      chk({tag, "_m_we"}, {31'd0, bus.o_m_we}, {31'd0, we});
      chk({tag, "_m_addr"}, {2'd0, bus.o_m_addr}, {2'd0, a[31:2]});
      chk({tag, "_m_be"}, {28'd0, bus.o_m_be}, {28'd0, ebe});
      if (we) chk({tag, "_m_wdata"}, bus.o_m_wdata, ewd);
      if (we) ref_store(a, f3, d);
      else    cq.push_back('{is_err: 1'b0, data: ref_load(a, f3), cyc: cyc});
    end else begin
      cq.push_back('{is_err: 1'b1, data: 32'd0, cyc: cyc});
    end
    @(posedge clk); #1;
    bus.i_c_req = 1'b0;
  endtask

  task automatic l_op(input bit we, input logic [31:0] a, input logic [31:0] d,
                      input bit expect_resp, input string tag);
    int n;
    bus.i_l_req = 1'b1; bus.i_l_we = we; bus.i_l_addr = a; bus.i_l_wdata = d;
    n = 0;
    @(negedge clk);
    while (!bus.o_l_gnt && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_gnt"}, {31'd0, bus.o_l_gnt}, 32'd1);
    chk({tag, "_m_en"}, {31'd0, bus.o_m_en}, 32'd1);
    chk({tag, "_m_addr"}, {2'd0, bus.o_m_addr}, {2'd0, a[31:2]});
    chk({tag, "_m_be"}, {28'd0, bus.o_m_be}, 32'hF);
    if (we) begin
      chk({tag, "_m_wdata"}, bus.o_m_wdata, d);
      ref_mem[a[11:2]] = d;
    end else if (expect_resp) begin
      lq.push_back('{is_err: 1'b0, data: ref_mem[a[11:2]], cyc: cyc});
    end
    @(posedge clk); #1;
    bus.i_l_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_c_gnt"}, {31'd0, bus.o_c_gnt}, 32'd0);
    chk({tag, "_l_gnt"}, {31'd0, bus.o_l_gnt}, 32'd0);
    chk({tag, "_m_en"}, {31'd0, bus.o_m_en}, 32'd0);
    chk({tag, "_c_rvalid"}, {31'd0, bus.o_c_rvalid}, 32'd0);
    chk({tag, "_l_rvalid"}, {31'd0, bus.o_l_rvalid}, 32'd0);
    chk({tag, "_c_err"}, {31'd0, bus.o_c_err}, 32'd0);
    chk({tag, "_c_rdata"}, bus.o_c_rdata, 32'd0);
    chk({tag, "_l_rdata"}, bus.o_l_rdata, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end
    rst = 1'b1;
    bus.i_c_req = 1'b1; bus.i_c_we = 1'b0; bus.i_c_addr = 32'h100;
    bus.i_c_wdata = 32'd0; bus.i_c_funct3 = 3'b010;
    bus.i_l_req = 1'b1; bus.i_l_we = 1'b0; bus.i_l_addr = 32'h200; bus.i_l_wdata = 32'd0;

    // Reset: requests present but nothing granted, all responses quiet.
    idle(2);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b0; bus.i_c_req = 1'b0; bus.i_l_req = 1'b0;
    idle(1);

    // Byte store replication and sign-extended byte load.
    c_op(1'b1, 3'b000, 32'h103, 32'h0000_00AB, "sb");
    c_op(1'b0, 3'b000, 32'h103, 32'd0, "lb");
    c_op(1'b1, 3'b001, 32'h0F2, 32'h0000_BEEF, "sh_hi");
    c_op(1'b0, 3'b101, 32'h0F2, 32'd0, "lhu_hi");

    // Lane extraction and extension from a loader-written word.
    l_op(1'b1, 32'h100, 32'h80F0_7F01, 1'b0, "l_st");
    c_op(1'b0, 3'b001, 32'h102, 32'd0, "lh");
    c_op(1'b0, 3'b101, 32'h102, 32'd0, "lhu");
    c_op(1'b0, 3'b100, 32'h101, 32'd0, "lbu");
    c_op(1'b0, 3'b000, 32'h102, 32'd0, "lb_neg");
    c_op(1'b0, 3'b010, 32'h100, 32'd0, "lw");
    l_op(1'b0, 32'h103, 32'd0, 1'b1, "l_rd");
    idle(1);

    // Starvation limit: L wins every fifth cycle under continuous contention.
    bus.i_c_req = 1'b1; bus.i_c_we = 1'b0; bus.i_c_funct3 = 3'b010; bus.i_c_addr = 32'h100;
    bus.i_l_req = 1'b1; bus.i_l_we = 1'b0; bus.i_l_addr = 32'h0F0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("starve_c_gnt", {31'd0, bus.o_c_gnt}, {31'd0, (k % 5) != 4});
      chk("starve_l_gnt", {31'd0, bus.o_l_gnt}, {31'd0, (k % 5) == 4});
      if ((k % 5) == 4) lq.push_back('{is_err: 1'b0, data: ref_mem[32'h0F0 >> 2], cyc: cyc});
      else              cq.push_back('{is_err: 1'b0, data: ref_load(32'h100, 3'b010), cyc: cyc});
      @(posedge clk); #1;
    end
    bus.i_c_req = 1'b0; bus.i_l_req = 1'b0;
    idle(1);

    // Misaligned and undefined accesses raise an error and issue nothing.
    c_op(1'b0, 3'b010, 32'h102, 32'd0, "lw_mis");
    c_op(1'b0, 3'b001, 32'h101, 32'd0, "lh_mis");
    c_op(1'b1, 3'b010, 32'h101, 32'h5555_5555, "sw_mis");
    c_op(1'b0, 3'b011, 32'h100, 32'd0, "f3_bad");
    c_op(1'b1, 3'b100, 32'h100, 32'd0, "sbu_bad");
    c_op(1'b0, 3'b010, 32'h100, 32'd0, "lw_after_err");

    // Write then read of the same word back to back.
    c_op(1'b1, 3'b010, 32'h200, 32'h1234_5678, "sw");
    c_op(1'b0, 3'b010, 32'h200, 32'd0, "lw_b2b");
    idle(1);
    @(negedge clk);
    chk("rdata_hold_rvalid", {31'd0, bus.o_c_rvalid}, 32'd0);
    chk("rdata_hold", bus.o_c_rdata, 32'h1234_5678);
    @(posedge clk); #1;

    // Reset right after a loader read grant drops the response.
    l_op(1'b0, 32'h200, 32'd0, 1'b0, "l_rd_rst");
    rst = 1'b1; bus.i_c_req = 1'b1; bus.i_l_req = 1'b1;
    @(negedge clk);
    chk_quiet("midrst");
    @(posedge clk); #1;
    rst = 1'b0; bus.i_c_req = 1'b0; bus.i_l_req = 1'b0;
    @(negedge clk);
    chk("post_rst_l_rvalid", {31'd0, bus.o_l_rvalid}, 32'd0);
    chk("post_rst_l_rdata", bus.o_l_rdata, 32'd0);
    @(posedge clk); #1;

    // Loader read after reset still works.
    l_op(1'b0, 32'h200, 32'd0, 1'b1, "l_rd_post");
    idle(3);
    chk("c_queue_drained", cq.size(), 32'd0);
    chk("l_queue_drained", lq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
